// File: rtl/chip8_reg_transfer.sv
// chip8_reg_transfer
//   Bulk register-file transfer sequencer for the CHIP-8 FX55 and FX65 opcodes.
//   - FX55 (op=0) stores V0..VX into memory starting at I.
//   - FX65 (op=1) loads V0..VX from memory starting at I.
//   The CPU is held off through `busy` until the transfer completes.
//
// Build option:
//   CHIP8_I_INCREMENT_EN
//     Defined: the DONE cycle pulses i_we with i_next = I + X + 1 (COSMAC behaviour).
//     Undefined: i_we = 0 and i_next = 0, so I is left unchanged (SCHIP behaviour).
//
// Ports:
//   cpu_clk, reset                    clock, synchronous active-high reset
//   start, op, last_reg, i_reg        request, direction, X and I, all sampled in IDLE
//   busy, done                        stall flag and one-cycle completion pulse
//   rf_addr, rf_we, rf_wdata, rf_rdata        register-file port 1 (read is combinational)
//   mem_addr, mem_we, mem_wdata, mem_rdata    main memory (read data arrives one cycle late)
//   i_next, i_we                      updated I value and its write strobe
//
// States:
//   state        | meaning
//   S_IDLE       | waiting for start; all strobes low
//   S_STORE      | Vk -> mem[base+k], one register per cycle
//   S_LOAD_ISSUE | mem[base] presented, waiting for its read data
//   S_LOAD_XFER  | mem data -> Vk while mem[base+k+1] is prefetched
//   S_DONE       | done pulse (and optional I update), then back to IDLE
module chip8_reg_transfer #(
  parameter int MEM_AW = 12
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [3:0]        last_reg,
  input  logic [15:0]       i_reg,
  output logic              busy,
  output logic              done,
  output logic [3:0]        rf_addr,
  output logic              rf_we,
  output logic [7:0]        rf_wdata,
  input  logic [7:0]        rf_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       i_next,
  output logic              i_we
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_LOAD_ISSUE,
    S_LOAD_XFER,
    S_DONE
  } state_t;

  state_t            state;
  logic [3:0]        x_q;
  logic [3:0]        k_q;
  logic [MEM_AW-1:0] base_q;
  logic              last_k;
  logic [MEM_AW-1:0] addr_k1;
  logic [MEM_AW-1:0] addr_k2;

`ifdef CHIP8_I_INCREMENT_EN
  logic [15:0] i_lat;
`else
  logic        unused_i_reg;
  assign unused_i_reg = ^i_reg;
  assign i_we   = 1'b0;
  assign i_next = '0;
`endif

  assign last_k  = (k_q == x_q);
  // Address arithmetic stays in MEM_AW bits, so it wraps at the top of memory.
  assign addr_k1 = base_q + MEM_AW'(k_q) + MEM_AW'(1);
  assign addr_k2 = addr_k1 + MEM_AW'(1);

  // Both data paths are pass-throughs: each byte is needed in the same cycle it
  // is read. Gating them with their strobe keeps the buses at 0 while idle.
  assign mem_wdata = mem_we ? rf_rdata : 8'h00;
  assign rf_wdata  = rf_we ? mem_rdata : 8'h00;

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rf_we    <= 1'b0;
      mem_we   <= 1'b0;
      rf_addr  <= '0;
      mem_addr <= '0;
      x_q      <= '0;
      k_q      <= '0;
      base_q   <= '0;
`ifdef CHIP8_I_INCREMENT_EN
      i_we     <= 1'b0;
      i_next   <= '0;
      i_lat    <= '0;
`endif
    end else begin
      done   <= 1'b0;
      rf_we  <= 1'b0;
      mem_we <= 1'b0;
`ifdef CHIP8_I_INCREMENT_EN
      i_we   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            x_q      <= last_reg;
            k_q      <= '0;
            base_q   <= i_reg[MEM_AW-1:0];
            busy     <= 1'b1;
            rf_addr  <= '0;
            mem_addr <= i_reg[MEM_AW-1:0];
`ifdef CHIP8_I_INCREMENT_EN
            i_lat    <= i_reg;
`endif
            if (op) begin
              state <= S_LOAD_ISSUE;
            end else begin
              state  <= S_STORE;
              mem_we <= 1'b1;
            end
          end
        end

        S_STORE: begin
          if (last_k) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            rf_addr  <= '0;
            mem_addr <= '0;
`ifdef CHIP8_I_INCREMENT_EN
            i_we     <= 1'b1;
            i_next   <= i_lat + 16'(x_q) + 16'd1;
`endif
          end else begin
            k_q      <= k_q + 4'd1;
            rf_addr  <= k_q + 4'd1;
            mem_addr <= addr_k1;
            mem_we   <= 1'b1;
          end
        end

        S_LOAD_ISSUE: begin
          state    <= S_LOAD_XFER;
          k_q      <= '0;
          rf_addr  <= '0;
          rf_we    <= 1'b1;
          // Prefetch base+1 while the byte for base is being written.
          mem_addr <= base_q + MEM_AW'(1);
        end

        S_LOAD_XFER: begin
          if (last_k) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            rf_addr  <= '0;
            mem_addr <= '0;
`ifdef CHIP8_I_INCREMENT_EN
            i_we     <= 1'b1;
            i_next   <= i_lat + 16'(x_q) + 16'd1;
`endif
          end else begin
            k_q      <= k_q + 4'd1;
            rf_addr  <= k_q + 4'd1;
            rf_we    <= 1'b1;
            mem_addr <= addr_k2;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/chip8_reg_transfer.md
# chip8_reg_transfer

Register-file transfer sequencer for the CHIP-8 CPU, executing the bulk opcodes FX55 (store V0..VX to memory at I) and FX65 (load V0..VX from memory at I). It is the client end of the register file's port-1 read/write interface: it drives register address, write enable and write data, and consumes read data. It sits between the instruction decoder and the 4 KB main memory, stalling the CPU via `busy` until the transfer completes.

## Interface
Parameters:
- `MEM_AW`, 12, memory address width; all memory addresses wrap modulo 2^MEM_AW.

Ports:
- `cpu_clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `op`  in  1  0 = store (FX55, regs to memory), 1 = load (FX65, memory to regs); sampled with `start`.
- `last_reg`  in  4  X; registers V0..VX inclusive are transferred.
- `i_reg`  in  16  current I; low MEM_AW bits form the base address; sampled with `start`.
- `busy`  out  1  high from cycle after accepted `start` through the final transfer cycle.
- `done`  out  1  one-cycle pulse after the final transfer cycle.
- `rf_addr`  out  4  register-file port-1 address.
- `rf_we`  out  1  register-file port-1 write enable.
- `rf_wdata`  out  8  register-file port-1 write data.
- `rf_rdata`  in  8  register-file port-1 read data; combinational from `rf_addr`.
- `mem_addr`  out  MEM_AW  memory address.
- `mem_we`  out  1  memory write enable.
- `mem_wdata`  out  8  memory write data.
- `mem_rdata`  in  8  memory read data; valid one cycle after `mem_addr` is presented.
- `i_next`  out  16  updated I value (see Configuration).
- `i_we`  out  1  one-cycle strobe to write `i_next` into I.

## Operation
- States: IDLE, STORE, LOAD_ISSUE, LOAD_XFER, DONE.
- IDLE: all strobes 0. `start`=1 latches `op`, `last_reg`, base = `i_reg[MEM_AW-1:0]`, clears counter k=0; next state STORE (op=0) or LOAD_ISSUE (op=1).
- STORE: each cycle `rf_addr`=k, `mem_addr`=base+k, `mem_wdata`=`rf_rdata`, `mem_we`=1. If k==X go DONE, else k++.
- LOAD_ISSUE: `mem_addr`=base+0, no writes; go LOAD_XFER with k=0.
- LOAD_XFER: `rf_addr`=k, `rf_we`=1, `rf_wdata`=`mem_rdata` (data for base+k); concurrently `mem_addr`=base+k+1 (prefetch). If k==X go DONE, else k++.
- DONE: `done`=1, `i_we` per Configuration; return IDLE.
- Address arithmetic: base+k computed in MEM_AW bits; base=0xFFF, k=1 wraps to 0x000.
- X=F includes VF; written through port 1 like any other register, no flag semantics.
- `start` while not IDLE ignored. `rf_we` and `mem_we` never both high.

## Timing
- Reset values: `busy`=0, `done`=0, `rf_we`=0, `mem_we`=0, `i_we`=0, `rf_addr`=0, `rf_wdata`=0, `mem_addr`=0, `mem_wdata`=0, `i_next`=0; state IDLE.
- `reset` mid-transfer: next edge returns IDLE, all strobes 0; partial writes already committed stay; no `done`.
- Store latency: X+1 write cycles, `done` in cycle X+2 after `start` edge.
- Load latency: 1 issue cycle + X+1 write cycles; `done` in cycle X+3.
- `start` may be reasserted in the cycle `done` is high is ignored; accepted from the following cycle (IDLE).

## Configuration
- `CHIP8_I_INCREMENT_EN` defined: in DONE, `i_next` = `i_reg`(latched) + X + 1 (16-bit wrap), `i_we`=1 for that cycle (original COSMAC behaviour).
- Undefined: `i_we` tied 0, `i_next` held 0; I unchanged (SCHIP behaviour).

## Test plan
- Store: V0..V3=0x11,0x22,0x33,0x44, `i_reg`=0x300, X=3 -> mem 0x300..0x303 = 0x11,0x22,0x33,0x44, exactly 4 `mem_we` cycles, `done` 5 cycles after start, no `rf_we`.
- Load: mem 0x200..0x20F = 0xA0..0xAF, X=F -> V0..VF = 0xA0..0xAF incl. VF=0xAF, `done` at cycle 18, `mem_we` never high.
- Wrap: store X=2 with `i_reg`=0x0FFF -> writes at 0xFFF, 0x000, 0x001.
- Reset mid-load at k=2 of X=7 -> V0,V1 updated only, V2..V7 unchanged, no `done`, outputs at reset values next cycle.
- Increment: with `CHIP8_I_INCREMENT_EN`, X=4, `i_reg`=0x400 -> `i_we` pulse with `i_next`=0x405 coincident with `done`; without macro `i_we` stays 0.
- `start` pulsed during busy with different `op` -> ignored; original transfer completes unchanged.
